// File: rtl/serial_regfile_seq_pkg.sv
// Shared mode encoding and width helpers for the bit-serial register file.
// Imported by the per-port sequencer and the top level.
package serial_regfile_seq_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_WRITE   = 2'd0,
        MODE_ROTATE  = 2'd1,
        MODE_CLEAR   = 2'd2,
        MODE_ROT_ALT = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } seq_state_t;

    // Step counter width: at least one bit even for single-step scans.
    function automatic int step_width(input int nsteps);
        return (nsteps <= 2) ? 1 : $clog2(nsteps);
    endfunction

endpackage

// File: rtl/serial_regfile_seq_scan_seq.sv
// Per-port scan sequencer: start/ready handshake, step counter, latched
// register index and mode for one scan port.
module serial_regfile_seq_scan_seq
    import serial_regfile_seq_pkg::*;
#(
    parameter int LOG2_NR = 3,
    parameter int NSTEPS  = 4,
    parameter int SW      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LOG2_NR-1:0] start_index,
    input  logic [MODE_W-1:0]  start_mode,
    output logic               start_ready,
    output logic               busy,
    output logic               last,
    output logic [SW-1:0]      step,
    output logic [LOG2_NR-1:0] index,
    output mode_t              mode
);

    localparam logic [SW-1:0] STEP_LAST = SW'(NSTEPS - 1);

    seq_state_t         state, state_nxt;
    logic [SW-1:0]      step_nxt;
    logic [LOG2_NR-1:0] index_nxt;
    mode_t              mode_nxt;
    logic               accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            step  <= '0;
            index <= '0;
            mode  <= MODE_WRITE;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            index <= index_nxt;
            mode  <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        index_nxt   = index;
        mode_nxt    = mode;
        busy        = (state == ST_SCAN);
        last        = busy && (step == STEP_LAST);
        start_ready = !busy || last;
        accept      = start && start_ready;

        // Accepting on the last step restarts the count with no idle bubble.
        if (accept) begin
            state_nxt = ST_SCAN;
            step_nxt  = '0;
            index_nxt = start_index;
            mode_nxt  = mode_t'(start_mode);
        end else begin
            case (state)
                ST_SCAN: begin
                    if (last) begin
                        state_nxt = ST_IDLE;
                        step_nxt  = '0;
                    end else begin
                        step_nxt = step + 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_regfile_seq.sv
// Bit-serial register file with NPORTS sequenced scan ports; each busy
// register shifts NSHIFT bits per cycle, lowest busy port supplying the input.
module serial_regfile_seq
    import serial_regfile_seq_pkg::*;
#(
    parameter int LOG2_NR   = 3,
    parameter int REG_BITS  = 8,
    parameter int NSHIFT    = 2,
    parameter int NPORTS    = 2,
    parameter int ZERO_REG0 = 0,
    localparam int NSTEPS   = REG_BITS / NSHIFT,
    localparam int SW       = step_width(NSTEPS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NPORTS-1:0]           start,
    input  logic [NPORTS*LOG2_NR-1:0]   start_index,
    input  logic [NPORTS*MODE_W-1:0]    start_mode,
    output logic [NPORTS-1:0]           start_ready,
    input  logic [NPORTS*NSHIFT-1:0]    scan_in,
    output logic [NPORTS*NSHIFT-1:0]    scan_out,
    output logic [NPORTS-1:0]           busy,
    output logic [NPORTS-1:0]           last,
    output logic [NPORTS*SW-1:0]        step
);

    localparam int NUM_REGS = 1 << LOG2_NR;

    logic [REG_BITS-1:0]                regs [NUM_REGS];
    logic [NPORTS-1:0][LOG2_NR-1:0]     port_idx;
    mode_t                              port_mode [NPORTS];
    logic [NPORTS-1:0][NSHIFT-1:0]      chunk_out;
    logic [NPORTS-1:0][NSHIFT-1:0]      chunk_in;
    logic [NUM_REGS-1:0]                reg_we;
    logic [NUM_REGS-1:0][NSHIFT-1:0]    reg_in;

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        logic [SW-1:0] step_k;

        serial_regfile_seq_scan_seq #(
            .LOG2_NR (LOG2_NR),
            .NSTEPS  (NSTEPS),
            .SW      (SW)
        ) u_seq (
            .clk         (clk),
            .reset       (reset),
            .start       (start[k]),
            .start_index (start_index[k*LOG2_NR +: LOG2_NR]),
            .start_mode  (start_mode[k*MODE_W +: MODE_W]),
            .start_ready (start_ready[k]),
            .busy        (busy[k]),
            .last        (last[k]),
            .step        (step_k),
            .index       (port_idx[k]),
            .mode        (port_mode[k])
        );

        assign step[k*SW +: SW] = step_k;

        // r0 is hard-wired to zero when ZERO_REG0 is set.
        assign chunk_out[k] = ((ZERO_REG0 != 0) && (port_idx[k] == '0)) ? '0
                            : regs[port_idx[k]][NSHIFT-1:0];

        assign chunk_in[k] = (port_mode[k] == MODE_WRITE) ? scan_in[k*NSHIFT +: NSHIFT]
                           : (port_mode[k] == MODE_CLEAR) ? '0
                           : chunk_out[k];

        assign scan_out[k*NSHIFT +: NSHIFT] = chunk_out[k];
    end

    // Walk ports high-to-low so the lowest-numbered colliding port wins.
    always_comb begin
        reg_we = '0;
        reg_in = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int k = NPORTS - 1; k >= 0; k--) begin
                if (busy[k] && (port_idx[k] == LOG2_NR'(r))) begin
                    reg_we[r] = 1'b1;
                    reg_in[r] = chunk_in[k];
                end
            end
        end
        if (ZERO_REG0 != 0) reg_we[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (reg_we[r])
                    regs[r] <= (regs[r] >> NSHIFT)
                             | (REG_BITS'(reg_in[r]) << (REG_BITS - NSHIFT));
            end
        end
    end

endmodule

// File: tb/tb_serial_regfile_seq.sv
// Randomised and directed checks of serial_regfile_seq against a behavioural
// model of the register file and per-port scan sequencing.
module tb_serial_regfile_seq;

    localparam int LOG2_NR  = 3;
    localparam int REG_BITS = 8;
    localparam int NSHIFT   = 2;
    localparam int NPORTS   = 2;
    localparam int NSTEPS   = REG_BITS / NSHIFT;
    localparam int SW       = 2;
    localparam int NR       = 1 << LOG2_NR;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start;
    logic [5:0] start_index;
    logic [3:0] start_mode;
    logic [1:0] start_ready;
    logic [3:0] scan_in;
    logic [3:0] scan_out;
    logic [1:0] busy;
    logic [1:0] last;
    logic [3:0] step;

    logic [1:0] z_start;
    logic [5:0] z_start_index;
    logic [3:0] z_start_mode;
    logic [1:0] z_start_ready;
    logic [3:0] z_scan_in;
    logic [3:0] z_scan_out;
    logic [1:0] z_busy;
    logic [1:0] z_last;
    logic [3:0] z_step;

    int checks = 0;
    int errors = 0;

    int mreg [NR];
    bit mbusy [NPORTS];
    int mstep [NPORTS];
    int midx  [NPORTS];
    int mmode [NPORTS];

    always #5 clk = ~clk;

    serial_regfile_seq #(.LOG2_NR(LOG2_NR), .REG_BITS(REG_BITS), .NSHIFT(NSHIFT),
                         .NPORTS(NPORTS), .ZERO_REG0(0)) dut (
        .clk(clk), .reset(reset), .start(start), .start_index(start_index),
        .start_mode(start_mode), .start_ready(start_ready), .scan_in(scan_in),
        .scan_out(scan_out), .busy(busy), .last(last), .step(step));

    serial_regfile_seq #(.LOG2_NR(LOG2_NR), .REG_BITS(REG_BITS), .NSHIFT(NSHIFT),
                         .NPORTS(NPORTS), .ZERO_REG0(1)) dut_z (
        .clk(clk), .reset(reset), .start(z_start), .start_index(z_start_index),
        .start_mode(z_start_mode), .start_ready(z_start_ready), .scan_in(z_scan_in),
        .scan_out(z_scan_out), .busy(z_busy), .last(z_last), .step(z_step));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_port(input int k, input bit s, input int idx, input int mode);
        start[k] = s;
        start_index[k*LOG2_NR +: LOG2_NR] = 3'(idx);
        start_mode[k*2 +: 2] = 2'(mode);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) mreg[r] = 0;
        for (int k = 0; k < NPORTS; k++) begin
            mbusy[k] = 0; mstep[k] = 0; midx[k] = 0; mmode[k] = 0;
        end
    endtask

    function automatic int mout(input int k);
        return mreg[midx[k]] % (1 << NSHIFT);
    endfunction

    // One clock of the reference: register shifts, then port sequencing.
    task automatic model_step();
        int nreg [NR];
        for (int r = 0; r < NR; r++) begin
            bit found = 0;
            nreg[r] = mreg[r];
            for (int k = 0; k < NPORTS; k++) begin
                if (!found && mbusy[k] && midx[k] == r) begin
                    int din;
                    found = 1;
                    if (mmode[k] == 0)      din = int'(scan_in[k*NSHIFT +: NSHIFT]);
                    else if (mmode[k] == 2) din = 0;
                    else                    din = mout(k);
                    nreg[r] = (mreg[r] >> NSHIFT) | (din << (REG_BITS - NSHIFT));
                end
            end
        end
        for (int k = 0; k < NPORTS; k++) begin
            bit rdy = !mbusy[k] || (mstep[k] == NSTEPS - 1);
            if (start[k] && rdy) begin
                mbusy[k] = 1; mstep[k] = 0;
                midx[k]  = int'(start_index[k*LOG2_NR +: LOG2_NR]);
                mmode[k] = int'(start_mode[k*2 +: 2]);
            end else if (mbusy[k]) begin
                if (mstep[k] == NSTEPS - 1) begin
                    mbusy[k] = 0; mstep[k] = 0;
                end else begin
                    mstep[k]++;
                end
            end
        end
        for (int r = 0; r < NR; r++) mreg[r] = nreg[r];
    endtask

    task automatic compare();
        for (int k = 0; k < NPORTS; k++) begin
            bit lst = mbusy[k] && (mstep[k] == NSTEPS - 1);
            chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(mbusy[k]));
            chk($sformatf("last[%0d]", k), 32'(last[k]), 32'(lst));
            chk($sformatf("ready[%0d]", k), 32'(start_ready[k]), 32'(!mbusy[k] || lst));
            chk($sformatf("step[%0d]", k), 32'(step[k*SW +: SW]), 32'(mstep[k]));
            if (mbusy[k])
                chk($sformatf("scan_out[%0d]", k), 32'(scan_out[k*NSHIFT +: NSHIFT]), 32'(mout(k)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    int rot_exp [4] = '{1, 2, 3, 0};

    initial begin
        reset = 1'b1;
        start = '0; start_index = '0; start_mode = '0; scan_in = '0;
        z_start = '0; z_start_index = '0; z_start_mode = '0; z_scan_in = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(start_ready), 3);
        chk("rst_step", 32'(step), 0);
        chk("rst_scan_out", 32'(scan_out), 0);
        reset = 1'b0;
        compare();

        // every register reads zero chunks after reset
        for (int r = 0; r < NR; r++) begin
            set_port(0, 1, r, 1); tick(); set_port(0, 0, r, 1);
            repeat (NSTEPS) begin
                chk("t1_zero_chunk", 32'(scan_out[1:0]), 0);
                tick();
            end
        end

        // port0 WRITE r3, then port1 ROTATE r3
        set_port(0, 1, 3, 0); tick(); set_port(0, 0, 3, 0);
        for (int i = 0; i < NSTEPS; i++) begin
            scan_in[1:0] = 2'(rot_exp[i]);
            tick();
        end
        scan_in = '0;
        chk("t2_model_r3", 32'(mreg[3]), 32'h39);
        set_port(1, 1, 3, 1); tick(); set_port(1, 0, 3, 1);
        for (int i = 0; i < NSTEPS; i++) begin
            chk("t2_rot_chunk", 32'(scan_out[3:2]), 32'(rot_exp[i]));
            tick();
        end
        chk("t2_r3_kept", 32'(mreg[3]), 32'h39);

        // start ignored mid-scan; back-to-back accept on last
        set_port(0, 1, 1, 1); tick(); set_port(0, 0, 1, 1);
        tick();
        chk("t3_step1", 32'(step[1:0]), 1);
        set_port(0, 1, 2, 1);
        chk("t3_not_ready", 32'(start_ready[0]), 0);
        tick();
        chk("t3_ignored_step", 32'(step[1:0]), 2);
        set_port(0, 0, 2, 1);
        tick();
        chk("t3_last", 32'(last[0]), 1);
        set_port(0, 1, 2, 1);
        tick();
        chk("t3_b2b_busy", 32'(busy[0]), 1);
        chk("t3_b2b_step", 32'(step[1:0]), 0);
        set_port(0, 0, 2, 1);
        repeat (NSTEPS) tick();

        // collision: both ports WRITE r5, port0 wins
        set_port(0, 1, 5, 0); set_port(1, 1, 5, 0); scan_in = 4'b0011;
        tick();
        set_port(0, 0, 5, 0); set_port(1, 0, 5, 0);
        repeat (NSTEPS) begin
            chk("t4_same_out", 32'(scan_out[3:2]), 32'(scan_out[1:0]));
            tick();
        end
        scan_in = '0;
        chk("t4_model_r5", 32'(mreg[5]), 32'hFF);
        set_port(1, 1, 5, 1); tick(); set_port(1, 0, 5, 1);
        repeat (NSTEPS) begin
            chk("t4_rot_ff", 32'(scan_out[3:2]), 3);
            tick();
        end

        // ZERO_REG0 instance: r0 ignores writes, r3 still works
        z_start = 2'b01; z_start_index = 6'd0; z_start_mode = 4'd0; z_scan_in = 4'b0011;
        tick(); z_start = '0;
        repeat (NSTEPS) tick();
        z_start = 2'b01; z_start_mode = 4'd1;
        tick(); z_start = '0;
        repeat (NSTEPS) begin
            chk("t5_z_busy", 32'(z_busy[0]), 1);
            chk("t5_z_r0_out", 32'(z_scan_out[1:0]), 0);
            tick();
        end
        z_start = 2'b01; z_start_index = 6'd3; z_start_mode = 4'd0;
        tick(); z_start = '0;
        repeat (NSTEPS) tick();
        z_start = 2'b01; z_start_mode = 4'd1;
        tick(); z_start = '0;
        chk("t5_z_r3_out", 32'(z_scan_out[1:0]), 3);
        repeat (NSTEPS) tick();
        z_scan_in = '0;

        // reset in the middle of a WRITE
        set_port(0, 1, 4, 0); scan_in = 4'b0011; tick(); set_port(0, 0, 4, 0);
        tick(); tick();
        chk("t6_step2", 32'(step[1:0]), 2);
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_busy_now", 32'(busy), 0);
        chk("t6_step_now", 32'(step), 0);
        @(negedge clk);
        reset = 1'b0;
        scan_in = '0;
        compare();
        set_port(0, 1, 4, 1); tick(); set_port(0, 0, 4, 1);
        repeat (NSTEPS) begin
            chk("t6_r4_zero", 32'(scan_out[1:0]), 0);
            tick();
        end

        // randomised traffic, concentrated on a few registers for collisions
        repeat (500) begin
            for (int k = 0; k < NPORTS; k++)
                set_port(k, ($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
            scan_in = 4'($urandom);
            tick();
        end
        start = '0;
        repeat (NSTEPS + 1) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
